// File: rtl/vga_pkg.sv
// Shared widths, screen geometry and arbiter state encoding for the VGA
// pixel-port arbiter and its helpers.
package vga_pkg;

    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int COL_W    = 3;
    localparam int X_SCREEN = 160;
    localparam int Y_SCREEN = 120;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        GAP  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first requester at or after
// (last winner + 1), wrapping, as a one-hot vector plus a valid flag.
module rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] iReq,
    input  logic [IDX_W-1:0]   iLast,
    output logic [NUM_REQ-1:0] oWinner,
    output logic               oValid
);

    always_comb begin
        oWinner = '0;
        oValid  = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            int idx;
            idx = (int'(iLast) + k) % NUM_REQ;
            if (!oValid && iReq[idx]) begin
                oWinner[idx] = 1'b1;
                oValid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_plot_arbiter.sv
// Round-robin owner arbitration for the single VGA pixel-write port, with
// off-screen clipping and forced revoke of owners that hold the port too long.
module vga_plot_arbiter
    import vga_pkg::*;
#(
    parameter int NUM_REQ         = 2,
    parameter int X_SCREEN_PIXELS = X_SCREEN,
    parameter int Y_SCREEN_PIXELS = Y_SCREEN,
    parameter int HOLD_LIMIT      = 19200
) (
    input  logic                     iClock,
    input  logic                     iResetn,
    input  logic [NUM_REQ-1:0]       iReq,
    input  logic [NUM_REQ-1:0]       iRelease,
    input  logic [X_W*NUM_REQ-1:0]   iX,
    input  logic [Y_W*NUM_REQ-1:0]   iY,
    input  logic [COL_W*NUM_REQ-1:0] iColour,
    input  logic [NUM_REQ-1:0]       iPlot,
    output logic [NUM_REQ-1:0]       oGrant,
    output logic [X_W-1:0]           oX,
    output logic [Y_W-1:0]           oY,
    output logic [COL_W-1:0]         oColour,
    output logic                     oPlot,
    output logic [NUM_REQ-1:0]       oTimeout
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(HOLD_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_LIMIT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(HOLD_LIMIT);

    arb_state_t         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [X_W-1:0]     x_q, x_d;
    logic [Y_W-1:0]     y_q, y_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic               plot_q, plot_d;
    logic [NUM_REQ-1:0] timeout_q, timeout_d;

    logic [NUM_REQ-1:0] pick_onehot;
    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;

    logic [X_W-1:0]     own_x;
    logic [Y_W-1:0]     own_y;
    logic [COL_W-1:0]   own_col;
    logic               own_plot, own_req, own_rel, on_screen, revoke;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .iReq    (iReq),
        .iLast   (owner_q),
        .oWinner (pick_onehot),
        .oValid  (pick_valid)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_onehot[i]) pick_idx = IDX_W'(i);
        end
    end

    // Owner index doubles as the last-winner pointer, so the mux and rotation share it.
    always_comb begin
        own_x    = '0;
        own_y    = '0;
        own_col  = '0;
        own_plot = 1'b0;
        own_req  = 1'b0;
        own_rel  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner_q == IDX_W'(i)) begin
                own_x    = iX[i*X_W +: X_W];
                own_y    = iY[i*Y_W +: Y_W];
                own_col  = iColour[i*COL_W +: COL_W];
                own_plot = iPlot[i];
                own_req  = iReq[i];
                own_rel  = iRelease[i];
            end
        end
        on_screen = (int'(own_x) < X_SCREEN_PIXELS) && (int'(own_y) < Y_SCREEN_PIXELS);
        revoke    = (cnt_q == CNT_LAST);
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        x_d       = x_q;
        y_d       = y_q;
        col_d     = col_q;
        plot_d    = 1'b0;
        timeout_d = '0;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = OWN;
                    grant_d = pick_onehot;
                    owner_d = pick_idx;
                    cnt_d   = '0;
                end
            end
            OWN: begin
                x_d    = own_x;
                y_d    = own_y;
                col_d  = own_col;
                plot_d = own_plot && on_screen;
                if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
                if (own_rel || !own_req || revoke) begin
                    state_d = GAP;
                    grant_d = '0;
                    // A voluntary release in the limit cycle is not a revoke.
                    if (revoke && own_req && !own_rel) timeout_d = grant_q;
                end
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            owner_q   <= IDX_W'(NUM_REQ - 1);
            cnt_q     <= '0;
            x_q       <= '0;
            y_q       <= '0;
            col_q     <= '0;
            plot_q    <= 1'b0;
            timeout_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            owner_q   <= owner_d;
            cnt_q     <= cnt_d;
            x_q       <= x_d;
            y_q       <= y_d;
            col_q     <= col_d;
            plot_q    <= plot_d;
            timeout_q <= timeout_d;
        end
    end

    assign oGrant   = grant_q;
    assign oX       = x_q;
    assign oY       = y_q;
    assign oColour  = col_q;
    assign oPlot    = plot_q;
    assign oTimeout = timeout_q;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Bench for vga_plot_arbiter: directed scenarios then random traffic, all
// checked against an ownership-level model of the arbiter.
module tb_vga_plot_arbiter;

    localparam int N    = 2;
    localparam int HOLD = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req, rel, plot;
    logic [8*N-1:0] xs;
    logic [7*N-1:0] ys;
    logic [3*N-1:0] cols;
    logic [N-1:0]   grant, tout;
    logic [7:0]     ox;
    logic [6:0]     oy;
    logic [2:0]     ocol;
    logic           oplot;

    int errors = 0;
    int checks = 0;

    // model state: current owner (-1 none), one-cycle gap flag, rotation pointer, cycles held
    int         m_owner, m_last, m_held;
    bit         m_gap;
    logic [N-1:0] e_grant, e_tout;
    logic [7:0] e_x;
    logic [6:0] e_y;
    logic [2:0] e_col;
    logic       e_plot;
    int         tout_seen;

    vga_plot_arbiter #(
        .NUM_REQ    (N),
        .HOLD_LIMIT (HOLD)
    ) dut (
        .iClock   (clk),
        .iResetn  (rst_n),
        .iReq     (req),
        .iRelease (rel),
        .iX       (xs),
        .iY       (ys),
        .iColour  (cols),
        .iPlot    (plot),
        .oGrant   (grant),
        .oX       (ox),
        .oY       (oy),
        .oColour  (ocol),
        .oPlot    (oplot),
        .oTimeout (tout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1; m_gap = 1'b0; m_last = N - 1; m_held = 0;
        e_grant = '0; e_tout = '0; e_x = '0; e_y = '0; e_col = '0; e_plot = 1'b0;
    endtask

    task automatic model_step();
        int o;
        e_plot = 1'b0;
        e_tout = '0;
        if (m_gap) begin
            m_gap = 1'b0;
        end else if (m_owner < 0) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_last + k) % N;
                if (m_owner < 0 && req[c]) begin
                    m_owner = c; m_last = c; m_held = 0;
                end
            end
        end else begin
            o = m_owner;
            e_x   = xs[8*o +: 8];
            e_y   = ys[7*o +: 7];
            e_col = cols[3*o +: 3];
            e_plot = plot[o] && (e_x < 160) && (e_y < 120);
            if (rel[o] || !req[o] || m_held == HOLD - 1) begin
                if (m_held == HOLD - 1 && req[o] && !rel[o]) e_tout[o] = 1'b1;
                m_owner = -1;
                m_gap = 1'b1;
            end else begin
                m_held++;
            end
        end
        e_grant = (m_owner < 0) ? '0 : (N'(1) << m_owner);
    endtask

    task automatic check_all();
        chk("grant", 32'(grant), 32'(e_grant));
        chk("plot", 32'(oplot), 32'(e_plot));
        chk("x", 32'(ox), 32'(e_x));
        chk("y", 32'(oy), 32'(e_y));
        chk("colour", 32'(ocol), 32'(e_col));
        chk("timeout", 32'(tout), 32'(e_tout));
        if (tout != '0) tout_seen++;
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic set_pix(input int n, input int x, input int y, input int c, input bit p);
        xs[8*n +: 8]   = 8'(x);
        ys[7*n +: 7]   = 7'(y);
        cols[3*n +: 3] = 3'(c);
        plot[n]        = p;
    endtask

    initial begin
        rst_n = 1'b0;
        req = '0; rel = '0; plot = '0; xs = '0; ys = '0; cols = '0;
        tout_seen = 0;
        model_reset();
        #12;
        chk("reset_grant", 32'(grant), 32'd0);
        chk("reset_plot", 32'(oplot), 32'd0);
        chk("reset_x", 32'(ox), 32'd0);
        chk("reset_timeout", 32'(tout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // single requester and first pixel
        req = 2'b01;
        step();
        chk("t1_grant", 32'(grant), 32'h1);
        set_pix(0, 10, 20, 5, 1'b1);
        step();
        chk("t1_x", 32'(ox), 32'd10);
        chk("t1_y", 32'(oy), 32'd20);
        chk("t1_col", 32'(ocol), 32'd5);
        chk("t1_plot", 32'(oplot), 32'd1);

        // non-owner pixels are dropped
        set_pix(0, 10, 20, 5, 1'b0);
        set_pix(1, 50, 50, 3, 1'b1);
        rel = 2'b10;
        step();
        rel = 2'b00;
        chk("t3_plot", 32'(oplot), 32'd0);
        chk("t3_x", 32'(ox), 32'd10);
        set_pix(1, 50, 50, 3, 1'b0);

        // clipping at both screen edges
        set_pix(0, 160, 0, 1, 1'b1);
        step();
        chk("t4_clip_x", 32'(oplot), 32'd0);
        chk("t4_clip_x_val", 32'(ox), 32'd160);
        set_pix(0, 0, 120, 2, 1'b1);
        step();
        chk("t4_clip_y", 32'(oplot), 32'd0);
        set_pix(0, 159, 119, 7, 1'b1);
        step();
        chk("t4_corner", 32'(oplot), 32'd1);
        set_pix(0, 0, 0, 0, 1'b0);

        // contention and alternation
        req = 2'b11;
        rel = 2'b01;
        step();
        rel = 2'b00;
        chk("t2_gap_grant", 32'(grant), 32'd0);
        step();
        step();
        chk("t2_grant1", 32'(grant), 32'h2);
        rel = 2'b10;
        step();
        rel = 2'b00;
        step();
        step();
        chk("t2_grant0", 32'(grant), 32'h1);

        // forced revoke: owner 0 never releases
        tout_seen = 0;
        for (int i = 0; i < 10; i++) step();
        chk("t5_grant_other", 32'(grant), 32'h2);
        chk("t5_pulses", 32'(tout_seen), 32'd1);
        req = 2'b00;
        for (int i = 0; i < 4; i++) step();

        // reset mid-draw clears outputs without a clock edge
        req = 2'b01;
        step();
        set_pix(0, 33, 44, 6, 1'b1);
        step();
        chk("t6_pre_plot", 32'(oplot), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_plot", 32'(oplot), 32'd0);
        chk("t6_grant", 32'(grant), 32'd0);
        chk("t6_x", 32'(ox), 32'd0);
        chk("t6_y", 32'(oy), 32'd0);
        chk("t6_col", 32'(ocol), 32'd0);
        model_reset();
        req = '0; plot = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // random traffic
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int n = 0; n < N; n++) begin
                if (!req[n]) req[n] = ($urandom_range(0, 3) == 0);
                else if ($urandom_range(0, 39) == 0) req[n] = 1'b0;
                rel[n] = ($urandom_range(0, 11) == 0);
                set_pix(n, $urandom_range(0, 175), $urandom_range(0, 127),
                        $urandom_range(0, 7), $urandom_range(0, 3) != 0);
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
